// File: rtl/whitening_pkg.sv
// whitening_pkg: shared definitions for the whitened-sample buffer (mem3 stage).
//   DW             signed sample width per channel
//   N_SAMPLES_DEF  default number of vectors stored per fill
//   ADDR_W_DEF     default address width
//   zbuf_state_e   buffer FSM encoding (idle / write / done)
//   abs_sat()      |v| that saturates at the largest positive value
package whitening_pkg;

  localparam int unsigned DW            = 16;
  localparam int unsigned N_SAMPLES_DEF = 8192;
  localparam int unsigned ADDR_W_DEF    = 14;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWrite = 2'd1,
    StDone  = 2'd2
  } zbuf_state_e;

  // Most-negative input has no positive counterpart, so clamp it to the max.
  function automatic logic [DW-1:0] abs_sat(input logic signed [DW-1:0] v);
    logic [DW-1:0] r;
    if (v == {1'b1, {(DW - 1){1'b0}}}) begin
      r = {1'b0, {(DW - 1){1'b1}}};
    end else if (v[DW-1]) begin
      r = -v;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/zbuf_ram.sv
// zbuf_ram: simple dual-port RAM, one write port and one registered read port.
//   clk_i    clock
//   we_i     write enable; waddr_i / wdata_i written on the rising edge
//   re_i     read enable; rdata_o updates one cycle later, holds otherwise
//   raddr_i  read address
// Contents are never reset.
module zbuf_ram #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned Depth = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/z_sample_writer.sv
// z_sample_writer: write side of the whitened-sample memory.
// Fills N_SAMPLES vectors {Z4,Z3,Z2,Z1} over a valid/ready handshake after GO_zbuf,
// then serves 1-cycle-latency random reads while in the done state.
// Ports:
//   CLK_zbuf, RSTn_zbuf    clock, synchronous active-low reset
//   GO_zbuf                start a fill (ignored while a fill is running)
//   Z_valid/Z_ready, Z1..Z4 sample input handshake and data
//   Rd_en, Rd_addr         read request; Rd_Z1..Rd_Z4 / Rd_valid one cycle later
//   Zbuf_busy, Zbuf_done   fill in progress / pulse after the last vector
//   Wr_count               vectors written in the current fill
//   Peak1..Peak4           per-channel peak |Z| of the current fill
// Build option: define ZBUF_PEAK_EN to build the peak trackers; otherwise Peak* read 0.
module z_sample_writer
  import whitening_pkg::*;
#(
  parameter int unsigned N_SAMPLES = N_SAMPLES_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF
) (
  input  logic          CLK_zbuf,
  input  logic          RSTn_zbuf,
  input  logic          GO_zbuf,
  input  logic          Z_valid,
  output logic          Z_ready,
  input  logic [DW-1:0] Z1,
  input  logic [DW-1:0] Z2,
  input  logic [DW-1:0] Z3,
  input  logic [DW-1:0] Z4,
  input  logic          Rd_en,
  input  logic [ADDR_W-1:0] Rd_addr,
  output logic [DW-1:0] Rd_Z1,
  output logic [DW-1:0] Rd_Z2,
  output logic [DW-1:0] Rd_Z3,
  output logic [DW-1:0] Rd_Z4,
  output logic          Rd_valid,
  output logic          Zbuf_busy,
  output logic          Zbuf_done,
  output logic [ADDR_W:0] Wr_count,
  output logic [DW-1:0] Peak1,
  output logic [DW-1:0] Peak2,
  output logic [DW-1:0] Peak3,
  output logic [DW-1:0] Peak4
);

  localparam logic [ADDR_W:0] NSamplesW = (ADDR_W + 1)'(N_SAMPLES);
  localparam logic [ADDR_W:0] LastIdx   = (ADDR_W + 1)'(N_SAMPLES - 1);

  zbuf_state_e state_q, state_d;

  logic [ADDR_W:0] wr_count_q;
  logic            done_q;
  logic            rd_valid_q;
  logic            rd_zero_q;   // last accepted read was out of range (or reset)
  logic            xfer;
  logic            last_xfer;
  logic            start_fill;
  logic            rd_accept;
  logic            rd_oor;
  logic [4*DW-1:0] ram_rdata;
  logic [4*DW-1:0] rd_word;

  assign xfer       = Z_valid & Z_ready;
  assign last_xfer  = xfer & (wr_count_q == LastIdx);
  assign start_fill = GO_zbuf & (state_q != StWrite);
  assign rd_accept  = Rd_en & (state_q == StDone);
  assign rd_oor     = ({1'b0, Rd_addr} >= NSamplesW);

  // State register
  always_ff @(posedge CLK_zbuf) begin
    if (!RSTn_zbuf) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (GO_zbuf) state_d = StWrite;
      StWrite: if (last_xfer) state_d = StDone;
      StDone:  if (GO_zbuf) state_d = StWrite;
      default: state_d = StIdle;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    Z_ready   = 1'b0;
    Zbuf_busy = 1'b0;
    unique case (state_q)
      StWrite: begin
        Z_ready   = 1'b1;
        Zbuf_busy = 1'b1;
      end
      default: ;
    endcase
  end

  // Write pointer, done pulse and read-side status
  always_ff @(posedge CLK_zbuf) begin
    if (!RSTn_zbuf) begin
      wr_count_q <= '0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_zero_q  <= 1'b1;
    end else begin
      done_q     <= last_xfer;
      rd_valid_q <= rd_accept;
      if (start_fill) begin
        wr_count_q <= '0;
      end else if (xfer) begin
        wr_count_q <= wr_count_q + 1'b1;
      end
      if (rd_accept) begin
        rd_zero_q <= rd_oor;
      end
    end
  end

  zbuf_ram #(
    .DATA_W (4 * DW),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (CLK_zbuf),
    .we_i    (xfer),
    .waddr_i (wr_count_q[ADDR_W-1:0]),
    .wdata_i ({Z4, Z3, Z2, Z1}),
    .re_i    (rd_accept & ~rd_oor),
    .raddr_i (Rd_addr),
    .rdata_o (ram_rdata)
  );

  // RAM read register and rd_zero_q both hold between accepted reads, so Rd_Z* hold too.
  assign rd_word = rd_zero_q ? '0 : ram_rdata;
  assign Rd_Z1   = rd_word[DW-1:0];
  assign Rd_Z2   = rd_word[2*DW-1:DW];
  assign Rd_Z3   = rd_word[3*DW-1:2*DW];
  assign Rd_Z4   = rd_word[4*DW-1:3*DW];

  assign Rd_valid  = rd_valid_q;
  assign Zbuf_done = done_q;
  assign Wr_count  = wr_count_q;

`ifdef ZBUF_PEAK_EN
  logic [DW-1:0] z_in   [4];
  logic [DW-1:0] peak_q [4];

  assign z_in[0] = Z1;
  assign z_in[1] = Z2;
  assign z_in[2] = Z3;
  assign z_in[3] = Z4;

  for (genvar k = 0; k < 4; k++) begin : g_peak
    logic [DW-1:0] mag;
    assign mag = abs_sat(z_in[k]);

    always_ff @(posedge CLK_zbuf) begin
      if (!RSTn_zbuf) begin
        peak_q[k] <= '0;
      end else if (start_fill) begin
        peak_q[k] <= '0;
      end else if (xfer && (mag > peak_q[k])) begin
        peak_q[k] <= mag;
      end
    end
  end

  assign Peak1 = peak_q[0];
  assign Peak2 = peak_q[1];
  assign Peak3 = peak_q[2];
  assign Peak4 = peak_q[3];
`else
  assign Peak1 = '0;
  assign Peak2 = '0;
  assign Peak3 = '0;
  assign Peak4 = '0;
`endif

endmodule

// File: tb/tb_z_sample_writer.sv
// Bench for z_sample_writer with N_SAMPLES=4, ADDR_W=3: reset, table-driven fill/readback,
// mid-fill reset and peak sequences, then random stimulus against a behavioural model.
module tb_z_sample_writer;

  localparam int NS = 4;
  localparam int AW = 3;

  logic        clk = 1'b0;
  logic        rstn;
  logic        go;
  logic        z_valid;
  logic        z_ready;
  logic [15:0] z1, z2, z3, z4;
  logic        rd_en;
  logic [AW-1:0] rd_addr;
  logic [15:0] rd_z1, rd_z2, rd_z3, rd_z4;
  logic        rd_valid;
  logic        busy;
  logic        done;
  logic [AW:0] wr_count;
  logic [15:0] peak1, peak2, peak3, peak4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  z_sample_writer #(
    .N_SAMPLES (NS),
    .ADDR_W    (AW)
  ) dut (
    .CLK_zbuf  (clk),
    .RSTn_zbuf (rstn),
    .GO_zbuf   (go),
    .Z_valid   (z_valid),
    .Z_ready   (z_ready),
    .Z1        (z1),
    .Z2        (z2),
    .Z3        (z3),
    .Z4        (z4),
    .Rd_en     (rd_en),
    .Rd_addr   (rd_addr),
    .Rd_Z1     (rd_z1),
    .Rd_Z2     (rd_z2),
    .Rd_Z3     (rd_z3),
    .Rd_Z4     (rd_z4),
    .Rd_valid  (rd_valid),
    .Zbuf_busy (busy),
    .Zbuf_done (done),
    .Wr_count  (wr_count),
    .Peak1     (peak1),
    .Peak2     (peak2),
    .Peak3     (peak3),
    .Peak4     (peak4)
  );

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit g, input bit v, input bit r, input int a,
                       input int d1, input int d2, input int d3, input int d4);
    go      = g;
    z_valid = v;
    rd_en   = r;
    rd_addr = AW'(a);
    z1      = 16'(d1);
    z2      = 16'(d2);
    z3      = 16'(d3);
    z4      = 16'(d4);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pattern used by the directed tests: vector k = {k, -k, 2k, 100+k}.
  task automatic drive_k(input bit g, input bit v, input bit r, input int a, input int k);
    drive(g, v, r, a, k, -k, 2 * k, 100 + k);
  endtask

  task automatic chk_rd(input string name, input int rk);
    if (rk < 0) begin
      chk({name, ".rd_z1"}, $signed(rd_z1), 0);
      chk({name, ".rd_z2"}, $signed(rd_z2), 0);
      chk({name, ".rd_z3"}, $signed(rd_z3), 0);
      chk({name, ".rd_z4"}, $signed(rd_z4), 0);
    end else begin
      chk({name, ".rd_z1"}, $signed(rd_z1), rk);
      chk({name, ".rd_z2"}, $signed(rd_z2), -rk);
      chk({name, ".rd_z3"}, $signed(rd_z3), 2 * rk);
      chk({name, ".rd_z4"}, $signed(rd_z4), 100 + rk);
    end
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    bit go;
    bit valid;
    bit rd;
    int addr;
    int k;        // input data index (vector pattern above)
    bit e_ready;  // also expected busy
    bit e_done;
    int e_cnt;
    bit e_rv;
    int e_rk;     // expected read pattern index, -1 = all zero
  } vec_t;

  function automatic vec_t row(bit g, bit v, bit r, int a, int k, bit er, bit ed, int ec,
                               bit erv, int erk);
    vec_t t;
    t.go = g; t.valid = v; t.rd = r; t.addr = a; t.k = k;
    t.e_ready = er; t.e_done = ed; t.e_cnt = ec; t.e_rv = erv; t.e_rk = erk;
    return t;
  endfunction

  // ---------------- behavioural reference model ----------------
  bit m_fill, m_full, m_done, m_rv;
  int m_cnt;
  int m_rz[4];
  int m_peak[4];
  int m_mem[NS][4];

  function automatic int abs_ref(input int v);
    int r = (v < 0) ? -v : v;
    return (r > 32767) ? 32767 : r;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int zin[4];
    zin[0] = $signed(z1); zin[1] = $signed(z2); zin[2] = $signed(z3); zin[3] = $signed(z4);
    if (!rstn) begin
      m_fill = 0; m_full = 0; m_cnt = 0; m_done = 0; m_rv = 0;
      for (int k = 0; k < 4; k++) begin m_rz[k] = 0; m_peak[k] = 0; end
    end else begin
      m_done = 0;
      m_rv   = 0;
      if (m_full && rd_en) begin
        m_rv = 1;
        for (int k = 0; k < 4; k++) m_rz[k] = (int'(rd_addr) < NS) ? m_mem[rd_addr][k] : 0;
      end
      if (m_fill) begin
        if (z_valid) begin
          for (int k = 0; k < 4; k++) begin
            m_mem[m_cnt][k] = zin[k];
            if (abs_ref(zin[k]) > m_peak[k]) m_peak[k] = abs_ref(zin[k]);
          end
          m_cnt++;
          if (m_cnt == NS) begin m_fill = 0; m_full = 1; m_done = 1; end
        end
      end else if (go) begin
        m_fill = 1; m_full = 0; m_cnt = 0;
        for (int k = 0; k < 4; k++) m_peak[k] = 0;
      end
    end
  endtask

  task automatic chk_model();
    int pk[4];
    for (int k = 0; k < 4; k++) begin
`ifdef ZBUF_PEAK_EN
      pk[k] = m_peak[k];
`else
      pk[k] = 0;
`endif
    end
    chk("rnd.ready", z_ready, m_fill);
    chk("rnd.busy", busy, m_fill);
    chk("rnd.done", done, m_done);
    chk("rnd.cnt", wr_count, m_cnt);
    chk("rnd.rv", rd_valid, m_rv);
    chk("rnd.rd_z1", $signed(rd_z1), m_rz[0]);
    chk("rnd.rd_z2", $signed(rd_z2), m_rz[1]);
    chk("rnd.rd_z3", $signed(rd_z3), m_rz[2]);
    chk("rnd.rd_z4", $signed(rd_z4), m_rz[3]);
    chk("rnd.peak1", peak1, pk[0]);
    chk("rnd.peak2", peak2, pk[1]);
    chk("rnd.peak3", peak3, pk[2]);
    chk("rnd.peak4", peak4, pk[3]);
  endtask

  initial begin
    vec_t tbl[20];
    int exp_peak;

    // ---- reset: 3 cycles low ----
    rstn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    chk("rst.ready", z_ready, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.cnt", wr_count, 0);
    chk("rst.rv", rd_valid, 0);
    chk_rd("rst", -1);
    chk("rst.peak1", peak1, 0);
    chk("rst.peak4", peak4, 0);
    rstn = 1'b1;

    // ---- table: throttled fill, readback, restart with GO on last transfer ----
    tbl[0]  = row(1, 0, 0, 0, 77, 1, 0, 0, 0, -1);
    tbl[1]  = row(0, 1, 0, 0, 0,  1, 0, 1, 0, -1);
    tbl[2]  = row(0, 0, 0, 0, 77, 1, 0, 1, 0, -1);
    tbl[3]  = row(0, 1, 0, 0, 1,  1, 0, 2, 0, -1);
    tbl[4]  = row(0, 0, 1, 2, 77, 1, 0, 2, 0, -1);
    tbl[5]  = row(0, 1, 0, 0, 2,  1, 0, 3, 0, -1);
    tbl[6]  = row(0, 0, 0, 0, 77, 1, 0, 3, 0, -1);
    tbl[7]  = row(0, 1, 0, 0, 3,  0, 1, 4, 0, -1);
    tbl[8]  = row(0, 0, 0, 0, 77, 0, 0, 4, 0, -1);
    tbl[9]  = row(0, 0, 1, 2, 77, 0, 0, 4, 1, 2);
    tbl[10] = row(0, 0, 1, 5, 77, 0, 0, 4, 1, -1);
    tbl[11] = row(0, 0, 1, 0, 77, 0, 0, 4, 1, 0);
    tbl[12] = row(0, 1, 0, 0, 55, 0, 0, 4, 0, 0);
    tbl[13] = row(1, 0, 0, 0, 77, 1, 0, 0, 0, 0);
    tbl[14] = row(0, 1, 1, 1, 10, 1, 0, 1, 0, 0);
    tbl[15] = row(0, 1, 0, 0, 11, 1, 0, 2, 0, 0);
    tbl[16] = row(1, 1, 0, 0, 12, 1, 0, 3, 0, 0);
    tbl[17] = row(1, 1, 0, 0, 13, 0, 1, 4, 0, 0);
    tbl[18] = row(0, 0, 1, 1, 77, 0, 0, 4, 1, 11);
    tbl[19] = row(0, 0, 1, 3, 77, 0, 0, 4, 1, 13);

    for (int i = 0; i < 20; i++) begin
      string nm;
      nm = $sformatf("tbl%0d", i);
      drive_k(tbl[i].go, tbl[i].valid, tbl[i].rd, tbl[i].addr, tbl[i].k);
      tick();
      chk({nm, ".ready"}, z_ready, tbl[i].e_ready);
      chk({nm, ".busy"}, busy, tbl[i].e_ready);
      chk({nm, ".done"}, done, tbl[i].e_done);
      chk({nm, ".cnt"}, wr_count, tbl[i].e_cnt);
      chk({nm, ".rv"}, rd_valid, tbl[i].e_rv);
      chk_rd(nm, tbl[i].e_rk);
    end

    // ---- reset mid-fill after 2 vectors ----
    drive_k(1, 0, 0, 0, 0); tick();
    drive_k(0, 1, 0, 0, 20); tick();
    drive_k(0, 1, 0, 0, 21); tick();
    chk("mid.cnt_before", wr_count, 2);
    rstn = 1'b0;
    drive_k(0, 0, 0, 0, 0); tick();
    rstn = 1'b1;
    chk("mid.cnt", wr_count, 0);
    chk("mid.ready", z_ready, 0);
    chk("mid.busy", busy, 0);
    drive_k(0, 0, 1, 0, 0); tick();
    chk("mid.rv", rd_valid, 0);
    drive_k(1, 0, 0, 0, 0); tick();
    for (int k = 30; k < 34; k++) begin drive_k(0, 1, 0, 0, k); tick(); end
    chk("mid.done", done, 1);
    chk("mid.cnt_full", wr_count, 4);
    drive_k(0, 0, 1, 3, 0); tick();
    chk("mid.rv_after", rd_valid, 1);
    chk_rd("mid.rd3", 33);

    // ---- peak saturation on channel 1 ----
    drive(1, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 0, 0, -32768, 0, 0, 0); tick();
    drive(0, 1, 0, 0, 5, 0, 0, 0); tick();
    drive(0, 1, 0, 0, -7, 0, 0, 0); tick();
    drive(0, 1, 0, 0, 3, 0, 0, 0); tick();
`ifdef ZBUF_PEAK_EN
    exp_peak = 32767;
`else
    exp_peak = 0;
`endif
    chk("peak.peak1", peak1, exp_peak);
    chk("peak.done", done, 1);
    drive(0, 0, 1, 0, 0, 0, 0, 0); tick();
    chk("peak.rd_z1", $signed(rd_z1), -32768);

    // ---- random stimulus against the model ----
    rstn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    model_step();
    tick();
    model_step();
    chk_model();
    for (int i = 0; i < 3000; i++) begin
      int d[4];
      for (int k = 0; k < 4; k++) begin
        d[k] = int'($urandom_range(0, 65535)) - 32768;
        if ($urandom_range(0, 15) == 0) d[k] = -32768;
      end
      rstn = ($urandom_range(0, 199) != 0);
      drive($urandom_range(0, 5) == 0, $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 7)), d[0], d[1], d[2], d[3]);
      tick();
      model_step();
      chk_model();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
